// File: rtl/mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_pkg : load-op codes, passthru field offsets, fwd bus width    |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package mem_pkg;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_B    = 3'd1;
  localparam logic [2:0] LD_H    = 3'd2;
  localparam logic [2:0] LD_W    = 3'd3;
  localparam logic [2:0] LD_BU   = 3'd4;
  localparam logic [2:0] LD_HU   = 3'd5;

  localparam int PC_LSB   = 0;
  localparam int RES_LSB  = 32;
  localparam int DEST_LSB = 64;
  localparam int GRWE_BIT = 69;

  localparam int FWD_W = 40;

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_load_align : selects and sign/zero-extends load data          |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module mem_load_align
  import mem_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase

    half_sel = addr[1] ? word[31:16] : word[15:0];

    case (ld_op)
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_BU:   result = {24'd0, byte_sel};
      LD_HU:   result = {16'd0, half_sel};
      default: result = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_stage : MEM pipeline stage (SRAM wait, load align, fwd bus)   |
// | Option macro: MEM_LOAD_FWD_EN (forward load data before WB)       |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module mem_stage
  import mem_pkg::*;
#(
  parameter int PASS_W   = 224,
  parameter int CANCEL_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ms_allowin,
  input  logic                es_to_ms_valid,
  input  logic [PASS_W+4:0]   es_to_ms_bus,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [PASS_W-1:0]   ms_to_ws_bus,
  output logic [FWD_W-1:0]    ms_fwd_bus,
  output logic                ms_ex,
  input  logic                flush
);

  logic                ms_valid;
  logic [PASS_W+4:0]   ms_bus;
  logic                rdata_buf_valid;
  logic [31:0]         rdata_buf;
  logic [CANCEL_W-1:0] discard_cnt;

  logic [2:0]          ld_op;
  logic                mem_req;
  logic                ex_any;
  logic [PASS_W-1:0]   passthru;
  logic [31:0]         addr_res;
  logic [4:0]          dest;
  logic                gr_we;

  logic                is_load;
  logic                waiting;
  logic                resp_ok;
  logic                ms_ready_go;
  logic                ms_leave;
  logic                cnt_inc;
  logic                cnt_dec;
  logic [31:0]         load_src;
  logic [31:0]         load_val;
  logic                ms_res_pending;
  logic [31:0]         ms_result;

  assign ld_op    = ms_bus[PASS_W+4:PASS_W+2];
  assign mem_req  = ms_bus[PASS_W+1];
  assign ex_any   = ms_bus[PASS_W];
  assign passthru = ms_bus[PASS_W-1:0];
  assign addr_res = passthru[RES_LSB +: 32];
  assign dest     = passthru[DEST_LSB +: 5];
  assign gr_we    = passthru[GRWE_BIT];

  assign is_load = (ld_op != LD_NONE);

  // Responses owed to flushed instructions are swallowed before ours counts.
  assign waiting     = ms_valid && mem_req && !ex_any && !rdata_buf_valid;
  assign resp_ok     = data_sram_data_ok && (discard_cnt == '0);
  assign ms_ready_go = !waiting || resp_ok;

  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
  assign ms_leave       = ms_valid && ms_ready_go && ws_allowin;
  assign ms_ex          = ms_valid && ex_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      ms_bus   <= '0;
    end else begin
      if (flush) begin
        ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        ms_bus <= es_to_ms_bus;
      end
    end
  end

  // Holds a response that arrived while WB was stalled; the SRAM won't repeat it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf_valid <= 1'b0;
      rdata_buf       <= '0;
    end else if (flush || ms_leave) begin
      rdata_buf_valid <= 1'b0;
    end else if (waiting && resp_ok && !ws_allowin) begin
      rdata_buf_valid <= 1'b1;
      rdata_buf       <= data_sram_rdata;
    end
  end

  // A flush that coincides with a discarded response nets to no change.
  assign cnt_inc = flush && waiting && !resp_ok;
  assign cnt_dec = data_sram_data_ok && (discard_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      discard_cnt <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      if (discard_cnt != '1) begin
        discard_cnt <= discard_cnt + CANCEL_W'(1);
      end
    end else if (cnt_dec && !cnt_inc) begin
      discard_cnt <= discard_cnt - CANCEL_W'(1);
    end
  end

  assign load_src = rdata_buf_valid ? rdata_buf : data_sram_rdata;

  mem_load_align u_align (
    .ld_op  (ld_op),
    .addr   (addr_res[1:0]),
    .word   (load_src),
    .result (load_val)
  );

  always_comb begin
    ms_to_ws_bus = passthru;
    if (is_load) begin
      ms_to_ws_bus[RES_LSB +: 32] = load_val;
    end
  end

`ifdef MEM_LOAD_FWD_EN
  assign ms_res_pending = ms_valid && is_load && !ms_ready_go;
  assign ms_result      = is_load ? load_val : addr_res;
`else
  assign ms_res_pending = ms_valid && is_load;
  assign ms_result      = addr_res;
`endif

  assign ms_fwd_bus = {ms_valid, ms_res_pending, gr_we, dest, ms_result};

endmodule
`default_nettype wire
